// File: rtl/wbs_run_pkg.sv
// rtl/wbs_run_pkg.sv - shared types and register map for the Wishbone run controller
package wbs_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_RUN   = 3'd3,
    ST_SEND  = 3'd4
  } run_state_t;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_STATUS   = 3'd1;
  localparam logic [2:0] REG_CYCLES   = 3'd2;
  localparam logic [2:0] REG_LOAD_LEN = 3'd3;
  localparam logic [2:0] REG_SEND_LEN = 3'd4;

  localparam int CTRL_LOAD_GO   = 0;
  localparam int CTRL_SEARCH_GO = 1;
  localparam int CTRL_SEND_GO   = 2;
  localparam int CTRL_ABORT     = 3;

  localparam int STAT_DONE = 3;
  localparam int STAT_ERR  = 4;

  // Hold length as programmed, with zero promoted to a single cycle
  function automatic logic [15:0] len_or_one(input logic [15:0] len);
    return (len == 16'd0) ? 16'd1 : len;
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// rtl/sync_rise_det.sv - two-flop synchroniser followed by a rising-edge pulse
module sync_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift the asynchronous level through two stages and keep one more for edge history
  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and history flops, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/wbs_run_ctrl.sv
// rtl/wbs_run_ctrl.sv - Wishbone-slave sequencer for load, search and send of the accelerator
module wbs_run_ctrl #(
  parameter logic [31:0] ADDR_BASE    = 32'h3000_0100,
  parameter logic [15:0] LOAD_LEN_RST = 16'd64,
  parameter logic [15:0] SEND_LEN_RST = 16'd1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        fsm_done,
  output logic        load_kdtree,
  output logic        fsm_start,
  output logic        send_best_arr,
  output logic        busy,
  output logic        irq
);

  import wbs_run_pkg::*;

  run_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] cycles_q, cycles_d;
  logic [15:0] load_len_q, load_len_d;
  logic [15:0] send_len_q, send_len_d;
  logic        done_sticky_q, done_sticky_d;
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic        win_hit;
  logic        req;
  logic        wr;
  logic        rd;
  logic [2:0]  reg_idx;
  logic        ctrl_wr;
  logic        status_wr;
  logic        abort;
  logic [2:0]  go_bits;
  logic        go_wr;
  logic        go_ok;
  logic        go_err;
  logic        done_rise;
  logic        done_set;
  logic [31:0] rdata;
  logic        unused_bits;

  sync_rise_det u_done_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .din  (fsm_done),
    .rise (done_rise)
  );

  // A new request is never taken in the ack cycle, so every access acks exactly once
  assign win_hit = (wbs_adr_i[31:5] == ADDR_BASE[31:5]);
  assign req     = wbs_stb_i & wbs_cyc_i & win_hit & ~ack_q;
  assign wr      = req & wbs_we_i;
  assign rd      = req & ~wbs_we_i;
  assign reg_idx = wbs_adr_i[4:2];

  assign ctrl_wr   = wr && (reg_idx == REG_CTRL) && wbs_sel_i[0];
  assign status_wr = wr && (reg_idx == REG_STATUS) && wbs_sel_i[0];
  assign abort     = ctrl_wr && wbs_dat_i[CTRL_ABORT];
  assign go_bits   = wbs_dat_i[2:0];
  // ABORT overrides any GO bits written alongside it
  assign go_wr     = ctrl_wr && !abort && (go_bits != 3'd0);
  assign go_ok     = go_wr && (state_q == ST_IDLE) && $onehot(go_bits);
  assign go_err    = go_wr && !go_ok;
  assign done_set  = (state_q == ST_RUN) && done_rise;

  assign unused_bits = &{1'b0, wbs_sel_i[3:2], wbs_dat_i[31:16], wbs_adr_i[1:0]};

  // Read-data mux over the register window; unmapped and write-only offsets read 0
  always_comb begin
    rdata = 32'd0;
    case (reg_idx)
      REG_STATUS: begin
        rdata[2:0]       = state_q;
        rdata[STAT_DONE] = done_sticky_q;
        rdata[STAT_ERR]  = err_q;
      end
      REG_CYCLES:   rdata = cycles_q;
      REG_LOAD_LEN: rdata = {16'd0, load_len_q};
      REG_SEND_LEN: rdata = {16'd0, send_len_q};
      default:      rdata = 32'd0;
    endcase
  end

  // Bus response and byte-lane writes to the length registers
  always_comb begin
    ack_d      = req;
    dat_d      = rd ? rdata : 32'd0;
    load_len_d = load_len_q;
    send_len_d = send_len_q;
    if (wr && (reg_idx == REG_LOAD_LEN)) begin
      if (wbs_sel_i[0]) load_len_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) load_len_d[15:8] = wbs_dat_i[15:8];
    end
    if (wr && (reg_idx == REG_SEND_LEN)) begin
      if (wbs_sel_i[0]) send_len_d[7:0]  = wbs_dat_i[7:0];
      if (wbs_sel_i[1]) send_len_d[15:8] = wbs_dat_i[15:8];
    end
  end

  // Run sequencer: next state, hold counter, cycle counter and sticky flags
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cycles_d      = cycles_q;
    done_sticky_d = done_sticky_q;
    err_d         = err_q;

    case (state_q)
      ST_IDLE: begin
        if (go_ok) begin
          if (go_bits[CTRL_LOAD_GO]) begin
            state_d = ST_LOAD;
            cnt_d   = len_or_one(load_len_q);
          end else if (go_bits[CTRL_SEARCH_GO]) begin
            state_d = ST_START;
          end else begin
            state_d = ST_SEND;
            cnt_d   = len_or_one(send_len_q);
          end
        end
      end
      ST_LOAD, ST_SEND: begin
        if (cnt_q <= 16'd1) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_START: begin
        cycles_d = 32'd0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (done_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) state_d = ST_IDLE;

    // Clear first so a same-cycle set takes priority over the W1C
    if (status_wr && wbs_dat_i[STAT_DONE]) done_sticky_d = 1'b0;
    if (status_wr && wbs_dat_i[STAT_ERR])  err_d = 1'b0;
    if (done_set) done_sticky_d = 1'b1;
    if (go_err)   err_d = 1'b1;
  end

  // All controller state, synchronously reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 16'd0;
      cycles_q      <= 32'd0;
      load_len_q    <= LOAD_LEN_RST;
      send_len_q    <= SEND_LEN_RST;
      done_sticky_q <= 1'b0;
      err_q         <= 1'b0;
      ack_q         <= 1'b0;
      dat_q         <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cycles_q      <= cycles_d;
      load_len_q    <= load_len_d;
      send_len_q    <= send_len_d;
      done_sticky_q <= done_sticky_d;
      err_q         <= err_d;
      ack_q         <= ack_d;
      dat_q         <= dat_d;
    end
  end

  assign wbs_ack_o     = ack_q;
  assign wbs_dat_o     = dat_q;
  assign load_kdtree   = (state_q == ST_LOAD);
  assign fsm_start     = (state_q == ST_START);
  assign send_best_arr = (state_q == ST_SEND);
  assign busy          = (state_q != ST_IDLE);
  assign irq           = done_sticky_q;

endmodule

// File: tb/tb_wbs_run_ctrl.sv
// tb/tb_wbs_run_ctrl.sv - randomized self-checking bench for wbs_run_ctrl
module tb_wbs_run_ctrl;

  localparam logic [31:0] BASE     = 32'h3000_0100;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_STATUS = BASE + 32'h04;
  localparam logic [31:0] A_CYCLES = BASE + 32'h08;
  localparam logic [31:0] A_LOAD   = BASE + 32'h0C;
  localparam logic [31:0] A_SEND   = BASE + 32'h10;
  localparam logic [31:0] A_RSV5   = BASE + 32'h14;
  localparam logic [31:0] A_RSV7   = BASE + 32'h1C;

  logic        clk;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        fsm_done;
  logic        load_kdtree, fsm_start, send_best_arr, busy, irq;

  int checks;
  int failures;
  int cyc;
  int tot_load, tot_send, tot_start, tot_busy;

  // Behavioural model of the programmer-visible registers
  logic [15:0] m_load_len, m_send_len;
  logic        m_sticky, m_err;
  logic [31:0] m_cycles;

  wbs_run_ctrl dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (wb_rst_i),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .fsm_done      (fsm_done),
    .load_kdtree   (load_kdtree),
    .fsm_start     (fsm_start),
    .send_best_arr (send_best_arr),
    .busy          (busy),
    .irq           (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load_kdtree)   tot_load  <= tot_load + 1;
    if (send_best_arr) tot_send  <= tot_send + 1;
    if (fsm_start)     tot_start <= tot_start + 1;
    if (busy)          tot_busy  <= tot_busy + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic int hold_len(input logic [15:0] len);
    return (len == 16'd0) ? 1 : int'(len);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // cap = {busy, load_kdtree, fsm_start, send_best_arr} sampled in the ack cycle
  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [3:0] cap);
    wbs_adr_i = adr;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_we_i  = 1'b1;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    step(1);
    chk("wr_ack", 32'(wbs_ack_o), 32'd1);
    cap = {busy, load_kdtree, fsm_start, send_best_arr};
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
    step(1);
    chk("wr_ack_width", 32'(wbs_ack_o), 32'd0);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] dat);
    wbs_adr_i = adr;
    wbs_sel_i = 4'hF;
    wbs_we_i  = 1'b0;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    step(1);
    chk("rd_ack", 32'(wbs_ack_o), 32'd1);
    dat = wbs_dat_o;
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    step(1);
    chk("rd_ack_width", 32'(wbs_ack_o), 32'd0);
  endtask

  task automatic check_status(input string tag, input int code);
    logic [31:0] d;
    logic [31:0] e;
    wb_read(A_STATUS, d);
    e = 32'd0;
    e[2:0] = code[2:0];
    e[3]   = m_sticky;
    e[4]   = m_err;
    chk(tag, d, e);
    chk("irq", 32'(irq), 32'(m_sticky));
  endtask

  task automatic model_reset();
    m_load_len = 16'd64;
    m_send_len = 16'd1024;
    m_sticky   = 1'b0;
    m_err      = 1'b0;
    m_cycles   = 32'd0;
  endtask

  task automatic do_len_write(input bit is_send, input logic [15:0] val, input logic [3:0] sel);
    logic [31:0] d;
    logic [3:0]  cap;
    d = {$urandom_range(0, 65535), val};
    d[31:16] = d[31:16] ^ 16'hA5A5;
    wb_write(is_send ? A_SEND : A_LOAD, d, sel, cap);
    if (is_send) begin
      if (sel[0]) m_send_len[7:0]  = d[7:0];
      if (sel[1]) m_send_len[15:8] = d[15:8];
    end else begin
      if (sel[0]) m_load_len[7:0]  = d[7:0];
      if (sel[1]) m_load_len[15:8] = d[15:8];
    end
    wb_read(is_send ? A_SEND : A_LOAD, d);
    chk("len_readback", d, {16'd0, is_send ? m_send_len : m_load_len});
  endtask

  // LOAD or SEND: output held for max(LEN,1) cycles starting with the ack
  task automatic do_hold(input bit is_send, input bit mid_len);
    int exp_n, b_l, b_s, b_st, b_b;
    logic [3:0] cap;
    exp_n = hold_len(is_send ? m_send_len : m_load_len);
    b_l = tot_load; b_s = tot_send; b_st = tot_start; b_b = tot_busy;
    wb_write(A_CTRL, is_send ? 32'h4 : 32'h1, 4'h1 | 4'($urandom_range(0, 15)), cap);
    chk("hold_at_ack", 32'(cap), is_send ? 32'b1001 : 32'b1100);
    if (exp_n >= 3) check_status("status_in_hold", is_send ? 4 : 1);
    if (mid_len && exp_n >= 5) do_len_write(is_send, 16'($urandom_range(0, 24)), 4'h3);
    for (int i = 0; i < 2100 && busy === 1'b1; i++) step(1);
    chk("hold_idle", 32'(busy), 32'd0);
    chk("hold_width", is_send ? 32'(tot_send - b_s) : 32'(tot_load - b_l), 32'(exp_n));
    chk("hold_busy", 32'(tot_busy - b_b), 32'(exp_n));
    chk("hold_other", is_send ? 32'(tot_load - b_l + tot_start - b_st)
                              : 32'(tot_send - b_s + tot_start - b_st), 32'd0);
    check_status("status_after_hold", 0);
  endtask

  // Search: latency counts every RUN cycle, which ends 3 cycles after fsm_done rises
  task automatic do_search(input int g, input bit err_wr);
    int b_st, b_sd, t_end, rem, ga;
    logic [3:0]  cap;
    logic [31:0] d;
    b_st = tot_start; b_sd = tot_send;
    wb_write(A_CTRL, 32'h2, 4'h1, cap);
    chk("start_at_ack", 32'(cap), 32'b1010);
    t_end = cyc;
    if (err_wr) begin
      wb_write(A_CTRL, 32'h4, 4'h1, cap);
      m_err = 1'b1;
      chk("go_in_run", 32'(cap), 32'b1000);
    end
    check_status("status_run", 3);
    rem = g - (cyc - t_end);
    if (rem > 0) step(rem);
    ga = cyc - t_end;
    fsm_done = 1'b1;
    step(2);
    chk("run_before_sync", 32'(busy), 32'd1);
    step(1);
    chk("idle_after_done", 32'(busy), 32'd0);
    m_sticky = 1'b1;
    m_cycles = 32'(ga + 3);
    chk("irq_after_done", 32'(irq), 32'(m_sticky));
    wb_read(A_CYCLES, d);
    chk("cycles", d, m_cycles);
    chk("start_pulses", 32'(tot_start - b_st), 32'd1);
    chk("send_in_search", 32'(tot_send - b_sd), 32'd0);
    fsm_done = 1'b0;
    step(3);
    check_status("status_after_search", 0);
  endtask

  // ABORT k cycles into RUN; GO bits written with it are ignored without err
  task automatic do_abort(input int k, input logic [2:0] gb);
    int t_end, t_ab;
    logic [3:0]  cap;
    logic [31:0] d;
    wb_write(A_CTRL, 32'h2, 4'h1, cap);
    t_end = cyc;
    step(k);
    t_ab = cyc;
    wb_write(A_CTRL, {28'd0, 1'b1, gb}, 4'h1, cap);
    chk("abort_ack", 32'(cap), 32'd0);
    m_cycles = 32'(t_ab - t_end + 1);
    wb_read(A_CYCLES, d);
    chk("cycles_abort", d, m_cycles);
    step(3);
    wb_read(A_CYCLES, d);
    chk("cycles_frozen", d, m_cycles);
    fsm_done = 1'b1;
    step(5);
    fsm_done = 1'b0;
    step(3);
    check_status("status_after_abort", 0);
  endtask

  task automatic do_illegal(input logic [31:0] v, input logic [3:0] sel);
    logic [3:0] cap;
    wb_write(A_CTRL, v, sel, cap);
    chk("illegal_idle", 32'(cap), 32'd0);
    if (sel[0]) m_err = 1'b1;
    check_status("status_illegal", 0);
  endtask

  task automatic do_w1c(input logic [31:0] d, input logic [3:0] sel);
    logic [3:0] cap;
    wb_write(A_STATUS, d, sel, cap);
    if (sel[0]) begin
      if (d[3]) m_sticky = 1'b0;
      if (d[4]) m_err = 1'b0;
    end
    check_status("status_w1c", 0);
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  cap;
    logic [31:0] multi [4];
    int acks;
    multi[0] = 32'h3; multi[1] = 32'h5; multi[2] = 32'h6; multi[3] = 32'h7;
    wb_rst_i  = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_dat_i = 32'd0; wbs_adr_i = 32'd0;
    fsm_done  = 1'b0;
    model_reset();
    step(3);
    wb_rst_i = 1'b0;
    step(1);

    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    chk("rst_ctl", 32'({busy, load_kdtree, fsm_start, send_best_arr, irq}), 32'd0);
    wb_read(A_CTRL, d);   chk("rst_ctrl", d, 32'd0);
    check_status("rst_status", 0);
    wb_read(A_CYCLES, d); chk("rst_cycles", d, m_cycles);
    wb_read(A_LOAD, d);   chk("rst_load_len", d, {16'd0, m_load_len});
    wb_read(A_SEND, d);   chk("rst_send_len", d, {16'd0, m_send_len});

    do_len_write(1'b0, 16'd5, 4'h3);
    do_hold(1'b0, 1'b0);
    do_search(20, 1'b0);
    do_w1c(32'h8, 4'h1);
    do_search(12, 1'b1);
    do_illegal(32'h3, 4'h1);
    do_len_write(1'b1, 16'd0, 4'h3);
    do_hold(1'b1, 1'b0);
    do_abort(10, 3'b010);

    for (int a = 0; a < 2; a++) begin
      wbs_adr_i = (a == 0) ? BASE + 32'h40 : BASE - 32'h4;
      wbs_we_i  = 1'b0;
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      acks = 0;
      for (int i = 0; i < 8; i++) begin
        step(1);
        if (wbs_ack_o) acks++;
      end
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      chk("miss_no_ack", 32'(acks), 32'd0);
    end
    wb_read(A_RSV7, d);
    chk("reserved_read", d, 32'd0);
    wb_write(A_RSV5, 32'hFFFF_FFFF, 4'hF, cap);
    wb_read(A_LOAD, d); chk("reserved_wr_load", d, {16'd0, m_load_len});
    wb_read(A_SEND, d); chk("reserved_wr_send", d, {16'd0, m_send_len});

    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 8))
        0: do_len_write(1'b0, 16'($urandom_range(0, 24)), 4'($urandom_range(0, 15)));
        1: do_len_write(1'b1, 16'($urandom_range(0, 24)), 4'($urandom_range(0, 15)));
        2: do_hold(1'b0, 1'($urandom_range(0, 1)));
        3: do_hold(1'b1, 1'($urandom_range(0, 1)));
        4: do_search($urandom_range(0, 30), 1'($urandom_range(0, 1)));
        5: do_abort($urandom_range(0, 15), 3'($urandom_range(0, 7)));
        6: do_illegal(multi[$urandom_range(0, 3)], 4'($urandom_range(0, 15)));
        7: do_w1c($urandom, 4'($urandom_range(0, 15)));
        default: begin
          wb_write(A_CTRL, {28'd0, 1'b1, 3'($urandom_range(1, 7))}, 4'h1, cap);
          chk("abort_idle", 32'(cap), 32'd0);
          check_status("status_abort_idle", 0);
        end
      endcase
    end

    do_len_write(1'b0, 16'd50, 4'h3);
    wb_write(A_CTRL, 32'h1, 4'h1, cap);
    chk("load_before_reset", 32'(cap), 32'b1100);
    step(4);
    wb_rst_i = 1'b1;
    step(1);
    chk("reset_mid_load", 32'({busy, load_kdtree, irq}), 32'd0);
    wb_rst_i = 1'b0;
    model_reset();
    wb_read(A_LOAD, d);   chk("reset_load_len", d, {16'd0, m_load_len});
    wb_read(A_SEND, d);   chk("reset_send_len", d, {16'd0, m_send_len});
    wb_read(A_CYCLES, d); chk("reset_cycles", d, m_cycles);
    check_status("reset_status", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
